// File: rtl/riscv_pkg.sv
// Shared integer-pipeline definitions: data width, register addressing and the
// long-latency writeback entry layout.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO with registered occupancy count; push into a full FIFO
// is refused even when a pop happens in the same cycle. Read data is the head, combinationally.
module wb_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_dat_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push, do_pop;

  assign full_o    = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign do_push   = push_i && !full_o;
  assign do_pop    = pop_i && !empty_o;
  assign pop_dat_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap naturally.
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !reset) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/writeback_unit.sv
// Merges ALU results and buffered long-latency responses onto the single
// register-file write port; tracks in-flight long-latency destinations and drives the write bypass.
module writeback_unit
  import riscv_pkg::*;
#(
  parameter int LL_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  ll_issue_valid,
  input  logic [REG_ADDR_W-1:0] ll_issue_rd,
  input  logic                  ll_resp_valid,
  output logic                  ll_resp_ready,
  input  logic [REG_ADDR_W-1:0] ll_resp_rd,
  input  logic [XLEN-1:0]       ll_resp_data,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]       rf_wdata,
  output logic [NUM_REGS-1:0]   pending,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  output logic                  byp1_hit,
  output logic                  byp2_hit,
  output logic [XLEN-1:0]       byp_data
);

  wb_entry_t incoming, fifo_head, head;
  logic      fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic      alu_claim, resp_fire, drain;

  logic                  rf_we_q, rf_we_d;
  logic [REG_ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0]       rf_wdata_q, rf_wdata_d;
  logic [NUM_REGS-1:0]   pending_q, pending_d;

  assign ll_resp_ready = !fifo_full && !reset;
  assign resp_fire     = ll_resp_valid && ll_resp_ready;
  assign alu_claim     = alu_valid && (alu_rd != '0);
  assign incoming      = '{rd: ll_resp_rd, data: ll_resp_data};

  // An empty buffer lets a fresh response go straight to the port.
  assign head      = fifo_empty ? incoming : fifo_head;
  assign drain     = !alu_claim && (!fifo_empty || resp_fire);
  assign fifo_push = resp_fire && !(fifo_empty && drain);
  assign fifo_pop  = drain && !fifo_empty;

  wb_fifo #(
    .WIDTH ($bits(wb_entry_t)),
    .DEPTH (LL_DEPTH)
  ) u_ll_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (fifo_push),
    .push_dat_i (incoming),
    .pop_i      (fifo_pop),
    .pop_dat_o  (fifo_head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    pending_d  = pending_q;
    if (alu_claim) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = alu_rd;
      rf_wdata_d = alu_data;
    end else if (drain && (head.rd != '0)) begin
      rf_we_d           = 1'b1;
      rf_waddr_d        = head.rd;
      rf_wdata_d        = head.data;
      pending_d[head.rd] = 1'b0;
    end
    // Applied after the clear so a same-cycle re-issue keeps the bit set.
    if (ll_issue_valid && (ll_issue_rd != '0)) pending_d[ll_issue_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      pending_q  <= '0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      pending_q  <= pending_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign pending  = pending_q;
  assign byp1_hit = rf_we_q && (rf_waddr_q == rs1) && (rs1 != '0);
  assign byp2_hit = rf_we_q && (rf_waddr_q == rs2) && (rs2 != '0);
  assign byp_data = rf_wdata_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: ALU vector table, directed multi-cycle
// sequences, then randomized traffic against a queue-based reference model.
module tb_writeback_unit;
  import riscv_pkg::*;

  localparam int LL_DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ll_issue_valid;
  logic [4:0]  ll_issue_rd;
  logic        ll_resp_valid;
  logic        ll_resp_ready;
  logic [4:0]  ll_resp_rd;
  logic [31:0] ll_resp_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] pending;
  logic [4:0]  rs1, rs2;
  logic        byp1_hit, byp2_hit;
  logic [31:0] byp_data;

  int tests = 0;
  int fails = 0;

  writeback_unit #(.LL_DEPTH(LL_DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .alu_valid      (alu_valid),
    .alu_rd         (alu_rd),
    .alu_data       (alu_data),
    .ll_issue_valid (ll_issue_valid),
    .ll_issue_rd    (ll_issue_rd),
    .ll_resp_valid  (ll_resp_valid),
    .ll_resp_ready  (ll_resp_ready),
    .ll_resp_rd     (ll_resp_rd),
    .ll_resp_data   (ll_resp_data),
    .rf_we          (rf_we),
    .rf_waddr       (rf_waddr),
    .rf_wdata       (rf_wdata),
    .pending        (pending),
    .rs1            (rs1),
    .rs2            (rs2),
    .byp1_hit       (byp1_hit),
    .byp2_hit       (byp2_hit),
    .byp_data       (byp_data)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        v;
    logic [4:0]  rd;
    logic [31:0] d;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        h1;
    logic        h2;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid      = 1'b0;
    alu_rd         = '0;
    alu_data       = '0;
    ll_issue_valid = 1'b0;
    ll_issue_rd    = '0;
    ll_resp_valid  = 1'b0;
    ll_resp_rd     = '0;
    ll_resp_data   = '0;
    rs1            = '0;
    rs2            = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic resp(input logic [4:0] rd, input logic [31:0] d);
    ll_resp_valid = 1'b1;
    ll_resp_rd    = rd;
    ll_resp_data  = d;
  endtask

  task automatic alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    alu_valid = v;
    alu_rd    = rd;
    alu_data  = d;
  endtask

  // Reference model state
  wb_entry_t   mq[$];
  logic [31:0] m_pend;
  logic        m_we;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;

  initial begin
    vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5, 5'd0,  1'b1, 5'd5,  32'hDEADBEEF, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 5'd9,  32'h00001111, 5'd5, 5'd5,  1'b0, 5'd5,  32'hDEADBEEF, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 5'd0,  32'h00002222, 5'd0, 5'd0,  1'b0, 5'd5,  32'hDEADBEEF, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 5'd31, 32'hA5A5A5A5, 5'd3, 5'd31, 1'b1, 5'd31, 32'hA5A5A5A5, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 5'd1,  32'h00000000, 5'd1, 5'd1,  1'b1, 5'd1,  32'h00000000, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 5'd12, 32'hFFFFFFFF, 5'd0, 5'd12, 1'b1, 5'd12, 32'hFFFFFFFF, 1'b0, 1'b1};

    // Reset state
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    check("rst_we", rf_we, 1'b0);
    check("rst_waddr", rf_waddr, 5'd0);
    check("rst_wdata", rf_wdata, 32'd0);
    check("rst_pending", pending, 32'd0);
    check("rst_ready_in_reset", ll_resp_ready, 1'b0);
    reset = 1'b0;
    #1;
    check("rst_ready_after", ll_resp_ready, 1'b1);

    // ALU vector table
    for (int i = 0; i < 6; i++) begin
      alu(vecs[i].v, vecs[i].rd, vecs[i].d);
      step();
      alu(1'b0, 5'd0, 32'd0);
      rs1 = vecs[i].r1;
      rs2 = vecs[i].r2;
      #1;
      check($sformatf("vec%0d_we", i), rf_we, vecs[i].we);
      check($sformatf("vec%0d_waddr", i), rf_waddr, vecs[i].wa);
      check($sformatf("vec%0d_wdata", i), rf_wdata, vecs[i].wd);
      check($sformatf("vec%0d_byp1", i), byp1_hit, vecs[i].h1);
      check($sformatf("vec%0d_byp2", i), byp2_hit, vecs[i].h2);
      if (vecs[i].h1 || vecs[i].h2) check($sformatf("vec%0d_bypdata", i), byp_data, vecs[i].wd);
    end

    // Issue then respond: scoreboard set and clear
    do_reset();
    ll_issue_valid = 1'b1; ll_issue_rd = 5'd7;
    step();
    ll_issue_valid = 1'b0;
    check("ll7_pending_set", pending, 32'h00000080);
    resp(5'd7, 32'h12345678);
    #1;
    check("ll7_ready", ll_resp_ready, 1'b1);
    step();
    ll_resp_valid = 1'b0;
    check("ll7_we", rf_we, 1'b1);
    check("ll7_waddr", rf_waddr, 5'd7);
    check("ll7_wdata", rf_wdata, 32'h12345678);
    check("ll7_pending_clr", pending, 32'd0);

    // Buffer fills under ALU pressure, then drains in order
    do_reset();
    alu(1'b1, 5'd10, 32'h1); resp(5'd3, 32'h33);
    step();
    check("fill1_ready", ll_resp_ready, 1'b1);
    alu(1'b1, 5'd11, 32'h2); resp(5'd4, 32'h44);
    step();
    check("fill2_ready", ll_resp_ready, 1'b0);
    alu(1'b1, 5'd12, 32'h3); resp(5'd5, 32'h55);
    step();
    check("stall_ready", ll_resp_ready, 1'b0);
    check("stall_alu_waddr", rf_waddr, 5'd12);
    alu(1'b1, 5'd0, 32'h4);
    step();
    check("drain3_we", rf_we, 1'b1);
    check("drain3_waddr", rf_waddr, 5'd3);
    check("drain3_wdata", rf_wdata, 32'h33);
    alu(1'b0, 5'd0, 32'h0);
    step();
    ll_resp_valid = 1'b0;
    check("drain4_waddr", rf_waddr, 5'd4);
    check("drain4_wdata", rf_wdata, 32'h44);
    step();
    check("drain5_waddr", rf_waddr, 5'd5);
    check("drain5_wdata", rf_wdata, 32'h55);
    step();
    check("drained_we", rf_we, 1'b0);

    // rd=0 traffic from both sources is never written, LL entries still consumed
    do_reset();
    alu(1'b1, 5'd0, 32'hAAAA); resp(5'd0, 32'hBBBB);
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("rd0_ready%0d", i), ll_resp_ready, 1'b1);
      step();
      check($sformatf("rd0_we%0d", i), rf_we, 1'b0);
    end
    idle_inputs();

    // Same-cycle clear and re-issue of x9
    do_reset();
    ll_issue_valid = 1'b1; ll_issue_rd = 5'd9;
    step();
    check("x9_pending_set", pending, 32'h00000200);
    resp(5'd9, 32'h99);
    step();
    idle_inputs();
    check("x9_we", rf_we, 1'b1);
    check("x9_waddr", rf_waddr, 5'd9);
    check("x9_pending_kept", pending, 32'h00000200);

    // Reset with a full buffer and pending bits
    do_reset();
    ll_issue_valid = 1'b1; ll_issue_rd = 5'd7;
    step();
    ll_issue_rd = 5'd8;
    step();
    ll_issue_valid = 1'b0;
    alu(1'b1, 5'd1, 32'h1); resp(5'd7, 32'h77);
    step();
    alu(1'b1, 5'd2, 32'h2); resp(5'd8, 32'h88);
    step();
    idle_inputs();
    check("prerst_pending", pending, 32'h00000180);
    check("prerst_ready", ll_resp_ready, 1'b0);
    reset = 1'b1;
    #1;
    check("midrst_ready", ll_resp_ready, 1'b0);
    step();
    reset = 1'b0;
    #1;
    check("postrst_we", rf_we, 1'b0);
    check("postrst_waddr", rf_waddr, 5'd0);
    check("postrst_wdata", rf_wdata, 32'd0);
    check("postrst_pending", pending, 32'd0);
    check("postrst_ready", ll_resp_ready, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("postrst_nostale%0d", i), rf_we, 1'b0);
    end

    // Randomized traffic against the reference model
    do_reset();
    mq.delete();
    m_pend = '0; m_we = 1'b0; m_wa = '0; m_wd = '0;
    for (int c = 0; c < 3000; c++) begin
      logic      fire, claim;
      wb_entry_t e;
      reset          = ($urandom_range(0, 99) == 0);
      alu_valid      = 1'($urandom_range(0, 1));
      alu_rd         = 5'($urandom_range(0, 7));
      alu_data       = $urandom;
      ll_issue_valid = 1'($urandom_range(0, 1));
      ll_issue_rd    = 5'($urandom_range(0, 15));
      ll_resp_valid  = 1'($urandom_range(0, 1));
      ll_resp_rd     = 5'($urandom_range(0, 15));
      ll_resp_data   = $urandom;
      rs1            = 5'($urandom_range(0, 15));
      rs2            = 5'($urandom_range(0, 15));
      #1;
      check("rnd_ready", ll_resp_ready, (!reset && mq.size() < LL_DEPTH) ? 1'b1 : 1'b0);
      if (reset) begin
        mq.delete();
        m_pend = '0; m_we = 1'b0; m_wa = '0; m_wd = '0;
      end else begin
        fire  = ll_resp_valid && (mq.size() < LL_DEPTH);
        claim = alu_valid && (alu_rd != 5'd0);
        if (fire) mq.push_back('{rd: ll_resp_rd, data: ll_resp_data});
        m_we = 1'b0;
        if (claim) begin
          m_we = 1'b1; m_wa = alu_rd; m_wd = alu_data;
        end else if (mq.size() > 0) begin
          e = mq.pop_front();
          if (e.rd != 5'd0) begin
            m_we = 1'b1; m_wa = e.rd; m_wd = e.data;
            m_pend[e.rd] = 1'b0;
          end
        end
        if (ll_issue_valid && ll_issue_rd != 5'd0) m_pend[ll_issue_rd] = 1'b1;
      end
      step();
      check("rnd_we", rf_we, m_we);
      check("rnd_waddr", rf_waddr, m_wa);
      check("rnd_wdata", rf_wdata, m_wd);
      check("rnd_pending", pending, m_pend);
      check("rnd_byp1", byp1_hit, (m_we && m_wa == rs1 && rs1 != 5'd0) ? 1'b1 : 1'b0);
      check("rnd_byp2", byp2_hit, (m_we && m_wa == rs2 && rs2 != 5'd0) ? 1'b1 : 1'b0);
      if (byp1_hit || byp2_hit) check("rnd_bypdata", byp_data, m_wd);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
# writeback_unit

Writeback stage directly upstream of the integer register file: merges single-cycle ALU results and long-latency (load/mul-div) responses onto the register file's single write port. Tracks destinations of in-flight long-latency operations in a scoreboard for issue-stall decisions. Supplies a bypass for the cycle in which a write is presented but not yet committed to the array.

## Interface
- XLEN, 32, data width
- LL_DEPTH, 2, long-latency response buffer entries (power of two, ≥2)

- clk  in  1  clock
- reset  in  1  synchronous, active-high
- alu_valid  in  1  ALU result present this cycle (no backpressure)
- alu_rd  in  5  ALU destination
- alu_data  in  XLEN  ALU result
- ll_issue_valid  in  1  long-latency op issued this cycle
- ll_issue_rd  in  5  its destination
- ll_resp_valid  in  1  long-latency response offered
- ll_resp_ready  out  1  response accepted when valid&&ready
- ll_resp_rd  in  5  response destination
- ll_resp_data  in  XLEN  response data
- rf_we, rf_waddr[5], rf_wdata[XLEN]  out  register-file write port, registered
- pending  out  32  scoreboard, bit i = x_i awaiting long-latency write
- rs1, rs2  in  5  decode read addresses
- byp1_hit, byp2_hit  out  1  rf write this cycle targets rs1/rs2
- byp_data  out  XLEN  equals rf_wdata (valid when a hit is high)

## Operation
- Write slot: ALU has absolute priority. ALU claims the slot when alu_valid && alu_rd!=0; otherwise slot is free.
- Free slot and LL buffer non-empty: pop head onto the write port.
- Neither: rf_we=0 next cycle; rf_waddr/rf_wdata hold previous values.
- rd=0 writes (either source) are dropped; never appear on rf_we. An LL response with rd=0 is still accepted and consumed.
- LL buffer: FIFO of {rd,data}, LL_DEPTH entries. ll_resp_ready = !full, forced 0 while reset high; no full-buffer pass-through (push into a full buffer refused even if a pop occurs the same cycle).
- Scoreboard:
  - ll_issue_valid && ll_issue_rd!=0 sets pending[rd].
  - Popping an entry onto the write port clears pending[rd] at the same edge that registers rf_we.
  - Set and clear of the same rd in one cycle: set wins.
  - pending[0] constant 0.
- Protocol violations (block still writes data; scoreboard unchanged beyond the rules above):
  - LL response to a non-pending rd: written normally.
  - ALU write to a pending rd: written normally.
- Bypass: byp1_hit = rf_we && rf_waddr==rs1 && rs1!=0; same for rs2. Combinational from registered state and rs inputs.

## Timing
- ALU result in cycle N → rf_we=1 in cycle N+1 → array updated at end of N+1. Bypass covers N+1.
- LL response accepted in cycle N → earliest rf_we in N+1 (empty buffer, free slot); each ALU-claimed cycle delays it by one.
- Sustained ALU stream starves LL; upstream bounds this by stalling issue.
- Reset (any cycle, including mid-drain):
  - rf_we=0, rf_waddr=0, rf_wdata=0, pending=0.
  - Buffer emptied, contents discarded; ll_resp_ready=0 during reset, 1 in the first cycle after.
  - Inputs ignored in reset cycles.

## Structure
- Shared package riscv_pkg: XLEN, REG_ADDR_W=5, NUM_REGS=32, packed wb_entry_t {rd, data}.
- Sub-module wb_fifo (parameterised depth, registered count, full/empty flags, synchronous reset). Arbitration, scoreboard and bypass live in writeback_unit.

## Test plan
- ALU x5=0xDEADBEEF in cycle 3 → rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF in cycle 4 only. rs1=5 in cycle 4 → byp1_hit=1, byp_data=0xDEADBEEF.
- Issue LL rd=7 → pending[7]=1 next cycle.
  - Response rd=7 data=0x12345678 while ALU idle → rf write next cycle, pending[7]=0 same edge.
- LL responses rd=3 and rd=4 accepted while ALU writes every cycle:
  - ll_resp_ready=0 after second push.
  - Third response stalls.
  - Drain begins in first ALU-idle or ALU-rd=0 cycle.
  - Order 3 then 4.
- ALU rd=0 and LL rd=0 traffic → rf_we never asserted. LL entry consumed.
- Same cycle: LL pop clears pending[9] and ll_issue_rd=9 → pending[9]=1 afterwards.
- Reset with 2 buffered entries and pending=0x00000180 → next cycle: rf_we=0, pending=0, buffer empty, ll_resp_ready=1; no stale writes appear.
